// File: rtl/b2b_pkg.sv
// rtl/b2b_pkg.sv - shared constants and state encoding for the bin2bcd controller and shift register
package b2b_pkg;

  localparam int B2B_BIN_W  = 16;
  localparam int B2B_DIGITS = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CORRECT = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } b2b_state_e;

  function automatic logic b2b_ge5(input logic [3:0] v);
    return v >= 4'd5;
  endfunction

endpackage

// File: rtl/b2b_add3.sv
// rtl/b2b_add3.sv - double-dabble add-3 correction of one BCD digit
module b2b_add3
  import b2b_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o,
  output logic       ge5_o
);

  assign ge5_o   = b2b_ge5(digit_i);
  // Wraps modulo 16, matching per-digit arithmetic of the downstream register.
  assign digit_o = ge5_o ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_ctrl.sv
// rtl/bin2bcd_ctrl.sv - sequencing controller for a shift-add-3 binary-to-BCD converter
// Define B2B_RESTART_EN to let start restart a conversion from CORRECT or SHIFT.
module bin2bcd_ctrl
  import b2b_pkg::*;
#(
  parameter int BIN_W  = B2B_BIN_W,
  parameter int DIGITS = B2B_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  reset_load,
  output logic                  shift_enable,
  output logic [DIGITS-1:0]     load_select,
  output logic [4*DIGITS-1:0]   corr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int                CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BIN_W - 1);

  b2b_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIGITS-1:0] ge5;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    b2b_add3 u_add3 (
      .digit_i (bcd_in[4*d +: 4]),
      .digit_o (corr_data[4*d +: 4]),
      .ge5_o   (ge5[d])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode only the registered state so they hold steady until the falling-edge capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reset_load   = 1'b0;
    shift_enable = 1'b0;
    load_select  = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        reset_load = 1'b1;
        busy       = 1'b1;
        cnt_d      = '0;
        state_d    = ST_CORRECT;
      end
      ST_CORRECT: begin
        busy        = 1'b1;
        load_select = ge5;
        state_d     = ST_SHIFT;
`ifdef B2B_RESTART_EN
        if (start) state_d = ST_LOAD;
`endif
      end
      ST_SHIFT: begin
        shift_enable = 1'b1;
        busy         = 1'b1;
        cnt_d        = cnt_q + CNT_W'(1);
        state_d      = (cnt_q == LAST_CNT) ? ST_DONE : ST_CORRECT;
`ifdef B2B_RESTART_EN
        if (start) state_d = ST_LOAD;
`endif
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// tb/tb_bin2bcd_ctrl.sv - randomized self-checking bench for bin2bcd_ctrl with a behavioural shift register
module tb_bin2bcd_ctrl;

  localparam logic [19:0] SEED = 20'h5A047;
`ifdef B2B_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] bcd_in;
  logic        reset_load;
  logic        shift_enable;
  logic [4:0]  load_select;
  logic [19:0] corr_data;
  logic        busy;
  logic        done;

  logic [15:0] operand = '0;
  logic [15:0] sh_bin;
  logic [19:0] sh_bcd;

  int total = 0;
  int bad   = 0;

  bin2bcd_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bcd_in       (bcd_in),
    .reset_load   (reset_load),
    .shift_enable (shift_enable),
    .load_select  (load_select),
    .corr_data    (corr_data),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  assign bcd_in = sh_bcd;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [19:0] corr_ref(input logic [19:0] b);
    logic [19:0] r;
    logic [3:0]  v;
    for (int d = 0; d < 5; d++) begin
      v = b[4*d +: 4];
      r[4*d +: 4] = (v >= 4'd5) ? v + 4'd3 : v;
    end
    return r;
  endfunction

  function automatic logic [19:0] apply_ls(input logic [19:0] b, input logic [4:0] ls,
                                           input logic [19:0] c);
    logic [19:0] r;
    r = b;
    for (int d = 0; d < 5; d++)
      if (ls[d]) r[4*d +: 4] = c[4*d +: 4];
    return r;
  endfunction

  // Downstream register: captures on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      sh_bcd <= SEED;
      sh_bin <= '0;
    end else if (reset_load) begin
      sh_bcd <= '0;
      sh_bin <= operand;
    end else if (shift_enable) begin
      {sh_bcd, sh_bin} <= {sh_bcd, sh_bin} << 1;
    end else begin
      sh_bcd <= apply_ls(sh_bcd, load_select, corr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic convert(input logic [15:0] op, input bit do_restart);
    int         e, done_e, rst_e, n_shift, n_load;
    bit         ls_seen, restarted, in_corr;
    logic [4:0] exp_ls;
    operand   = op;
    done_e    = -1;
    rst_e     = 0;
    n_shift   = 0;
    n_load    = 0;
    ls_seen   = 1'b0;
    restarted = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    e = 0;
    while (e < 200) begin
      in_corr = busy && !reset_load && !shift_enable;
      exp_ls  = '0;
      if (in_corr)
        for (int d = 0; d < 5; d++) exp_ls[d] = (bcd_in[4*d +: 4] >= 4'd5);
      check("load_select", 32'(load_select), 32'(exp_ls));
      check("corr_data", 32'(corr_data), 32'(corr_ref(bcd_in)));
      check("onehot", 32'((int'(reset_load) + int'(shift_enable) + int'(|load_select)) <= 1), 32'd1);
      n_shift += int'(shift_enable);
      n_load  += int'(reset_load);
      if (|load_select) ls_seen = 1'b1;
      if (done) begin
        done_e = e;
        break;
      end
      if (do_restart && !restarted && in_corr) begin
        start     = 1'b1;
        restarted = 1'b1;
        rst_e     = e + 1;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      e++;
    end
    check("done_edge", 32'(done_e), 32'((do_restart && RESTART) ? rst_e + 33 : 33));
    check("bcd", 32'(sh_bcd), 32'(to_bcd(int'(op))));
    check("n_shift", 32'(n_shift), 32'd16);
    check("n_load", 32'(n_load), (do_restart && RESTART) ? 32'd2 : 32'd1);
    if (op == 16'd0) check("ls_never", 32'(ls_seen), 32'd0);
    // A start presented while DONE must not launch a new conversion.
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #1;
    check("rst_reset_load", 32'(reset_load), 32'd0);
    check("rst_shift_enable", 32'(shift_enable), 32'd0);
    check("rst_load_select", 32'(load_select), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_corr", 32'(corr_data), 32'h8D04A);
    @(negedge clock);
    reset = 1'b0;

    convert(16'd0, 1'b0);
    convert(16'hFFFF, 1'b0);
    convert(16'd255, 1'b0);
    convert(16'd9999, 1'b0);
    convert(16'd7, 1'b1);

    operand = 16'hBEEF;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    for (int g = 0; g < 100; g++) begin
      if (shift_enable) n++;
      if (n == 10) break;
      @(posedge clock);
      #1;
    end
    check("rst_reach_shift10", 32'(n), 32'd10);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_load", 32'(reset_load), 32'd0);
    check("mid_shift_enable", 32'(shift_enable), 32'd0);
    check("mid_load_select", 32'(load_select), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check("mid_no_done", 32'(done), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_rst_idle", 32'(busy | done), 32'd0);
    convert(16'd42, 1'b0);

    for (int i = 0; i < 12; i++)
      convert(16'($urandom_range(0, 65535)), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/bin2bcd_ctrl.md
BIN2BCD_CTRL -- requirements
Module: bin2bcd_ctrl

Interface
REQ-001 SHALL have parameter BIN_W, default 16, meaning binary operand width and number of shift iterations.
REQ-002 SHALL have parameter DIGITS, default 5, meaning BCD digit count; BCD bus width is 4*DIGITS.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a conversion; sampled on the rising edge in IDLE.
REQ-006 SHALL have port bcd_in  input  4*DIGITS  current BCD field returned from the downstream shift register.
REQ-007 SHALL have port reset_load  output  1  load operand / clear BCD field in the shift register.
REQ-008 SHALL have port shift_enable  output  1  shift the register left by one bit.
REQ-009 SHALL have port load_select  output  DIGITS  per-digit write enable for corrected digits.
REQ-010 SHALL have port corr_data  output  4*DIGITS  add-3-corrected BCD field.
REQ-011 SHALL have port busy  output  1  conversion in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse; shift register output is final.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, CORRECT, SHIFT, DONE, held in a registered state vector.
REQ-014 SHALL transition IDLE->LOAD on start=1, and otherwise remain in IDLE.
REQ-015 SHALL transition LOAD->CORRECT unconditionally and clear the iteration counter to 0.
REQ-016 SHALL transition CORRECT->SHIFT unconditionally.
REQ-017 SHALL transition SHIFT->CORRECT while the counter is below BIN_W-1 and SHIFT->DONE when it equals BIN_W-1, incrementing the counter on each SHIFT.
REQ-018 SHALL transition DONE->IDLE unconditionally.
REQ-019 SHALL give a total latency for default parameters of 34 cycles: start sampled at edge 0, done high in the cycle after edge 33.
REQ-020 SHALL decode reset_load=1 only in LOAD and shift_enable=1 only in SHIFT, both from the registered state only.
REQ-021 SHALL, for each digit d, set corr_data[d] = bcd_in[d]+3 when bcd_in[d] >= 5, else bcd_in[d], with modulo-16 arithmetic per digit.
REQ-022 SHALL drive load_select[d] = (bcd_in[d] >= 5) in CORRECT and 0 in every other state.
REQ-023 SHALL never assert shift_enable, reset_load and any load_select bit simultaneously.
REQ-024 SHALL keep all outputs stable from the rising edge until the downstream falling-edge sample, since the downstream register captures on the falling edge.
REQ-025 SHALL assert busy in LOAD, CORRECT and SHIFT, and assert done only in DONE.
REQ-026 SHALL treat start in DONE as ignored; a new start is accepted only in IDLE.

Reset
REQ-027 SHALL, while reset=1, force state to IDLE and the counter to 0 immediately, independent of clock.
REQ-028 SHALL drive reset values reset_load=0, shift_enable=0, load_select=0, busy=0, done=0, with corr_data following bcd_in combinationally.
REQ-029 SHALL, on reset mid-conversion, abandon the conversion without asserting done; downstream contents are undefined until the next LOAD.

Configuration
REQ-030 SHALL, with macro B2B_RESTART_EN defined, have start=1 in CORRECT or SHIFT force the next state to LOAD (conversion restarts, counter cleared).
REQ-031 SHALL, without B2B_RESTART_EN, ignore start outside IDLE.

Structure
REQ-032 SHALL define state encodings and default BIN_W/DIGITS constants in shared package b2b_pkg, used by this block and the shift register.
REQ-033 SHALL implement per-digit correction in sub-module b2b_add3 (4-bit in, 4-bit out, ge5 flag), instantiated DIGITS times.

Verification
REQ-034 SHALL verify: operand 16'd0 -> bcd 20'h00000, load_select never nonzero, done pulse in the cycle after edge 33.
REQ-035 SHALL verify: operand 16'hFFFF -> bcd 20'h65535; exactly 16 shift_enable pulses and 1 reset_load pulse.
REQ-036 SHALL verify: operand 16'd255 -> bcd 20'h00255; operand 16'd9999 -> bcd 20'h09999.
REQ-037 SHALL verify: reset asserted during the 10th SHIFT -> all control outputs 0 immediately, no done; a following start with operand 16'd42 -> bcd 20'h00042.
REQ-038 SHALL verify: start re-asserted during CORRECT with 16'd7 loaded -> with B2B_RESTART_EN, reset_load pulses again and done arrives 34 cycles after the restart; without it, done arrives on the original schedule.
REQ-039 SHALL verify: a checker flags any cycle where more than one of reset_load, shift_enable, |load_select is high.
